// File: rtl/siphash_ctrl.sv
// Iterative SipHash-c-d sequencer: one SipRound per clock, C_ROUNDS per message word,
// D_ROUNDS for finalization, tag returned over a valid/ready handshake.
module siphash_ctrl #(
    parameter int C_ROUNDS = 2,
    parameter int D_ROUNDS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    input  logic [63:0]  msg_data,
    input  logic [2:0]   msg_bytes,
    input  logic         msg_last,
    input  logic         msg_valid,
    output logic         msg_ready,
    output logic [63:0]  hash,
    output logic         hash_valid,
    input  logic         hash_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_COMP,
        S_FIN,
        S_DONE
    } state_t;

    localparam logic [3:0] C_LAST = 4'(C_ROUNDS - 1);
    localparam logic [3:0] D_LAST = 4'(D_ROUNDS - 1);

    state_t      state_reg;
    logic [63:0] v0_reg, v1_reg, v2_reg, v3_reg;
    logic [63:0] m_reg;
    logic [7:0]  len_reg;
    logic [3:0]  rcnt_reg;
    logic        last_f_reg;
    logic        busy_reg;
    logic        msg_ready_reg;
    logic        hash_valid_reg;
    logic [63:0] hash_reg;

    assign busy       = busy_reg;
    assign msg_ready  = msg_ready_reg;
    assign hash_valid = hash_valid_reg;
    assign hash       = hash_reg;

    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    // SipRound datapath: two chained half-rounds on the current state.
    logic [63:0] h0, h1, h2, h3;
    logic [63:0] s2;
    logic [63:0] round_v0_next, round_v1_next, round_v2_next, round_v3_next;

    always_comb begin
        h0 = rotl(v0_reg + v1_reg, 32);
        h1 = rotl(v1_reg, 13) ^ (v0_reg + v1_reg);
        h2 = v2_reg + v3_reg;
        h3 = rotl(v3_reg, 16) ^ (v2_reg + v3_reg);
        s2 = h2 + h1;
        round_v1_next = rotl(h1, 17) ^ s2;
        round_v2_next = rotl(s2, 32);
        round_v0_next = h0 + h3;
        round_v3_next = rotl(h3, 21) ^ (h0 + h3);
    end

    // Beat formatting: on the last beat unused bytes are zeroed and byte 7 carries the length.
    logic [63:0] blk_word;

    for (genvar gi = 0; gi < 8; gi++) begin : g_blk
        if (gi == 7) begin : g_len
            assign blk_word[63:56] = msg_last ? (len_reg + {5'b0, msg_bytes}) : msg_data[63:56];
        end else begin : g_data
            assign blk_word[gi*8 +: 8] = (msg_last && (msg_bytes <= 3'(gi))) ? 8'h00
                                                                             : msg_data[gi*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            v0_reg         <= '0;
            v1_reg         <= '0;
            v2_reg         <= '0;
            v3_reg         <= '0;
            m_reg          <= '0;
            len_reg        <= '0;
            rcnt_reg       <= '0;
            last_f_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            msg_ready_reg  <= 1'b0;
            hash_valid_reg <= 1'b0;
            hash_reg       <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        v0_reg        <= key[63:0]   ^ 64'h736f6d6570736575;
                        v1_reg        <= key[127:64] ^ 64'h646f72616e646f6d;
                        v2_reg        <= key[63:0]   ^ 64'h6c7967656e657261;
                        v3_reg        <= key[127:64] ^ 64'h7465646279746573;
                        len_reg       <= '0;
                        busy_reg      <= 1'b1;
                        msg_ready_reg <= 1'b1;
                        state_reg     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (msg_valid) begin
                        m_reg         <= blk_word;
                        v3_reg        <= v3_reg ^ blk_word;
                        rcnt_reg      <= '0;
                        msg_ready_reg <= 1'b0;
                        state_reg     <= S_COMP;
                        if (msg_last) begin
                            last_f_reg <= 1'b1;
                            len_reg    <= len_reg + {5'b0, msg_bytes};
                        end else begin
                            len_reg    <= len_reg + 8'd8;
                        end
                    end
                end
                S_COMP: begin
                    v1_reg <= round_v1_next;
                    v3_reg <= round_v3_next;
                    if (rcnt_reg == C_LAST) begin
                        v0_reg   <= round_v0_next ^ m_reg;
                        v2_reg   <= last_f_reg ? (round_v2_next ^ 64'h00000000000000ff) : round_v2_next;
                        rcnt_reg <= '0;
                        if (last_f_reg) begin
                            state_reg <= S_FIN;
                        end else begin
                            msg_ready_reg <= 1'b1;
                            state_reg     <= S_WAIT;
                        end
                    end else begin
                        v0_reg   <= round_v0_next;
                        v2_reg   <= round_v2_next;
                        rcnt_reg <= rcnt_reg + 4'd1;
                    end
                end
                S_FIN: begin
                    v0_reg <= round_v0_next;
                    v1_reg <= round_v1_next;
                    v2_reg <= round_v2_next;
                    v3_reg <= round_v3_next;
                    if (rcnt_reg == D_LAST) begin
                        hash_reg       <= round_v0_next ^ round_v1_next ^ round_v2_next ^ round_v3_next;
                        hash_valid_reg <= 1'b1;
                        state_reg      <= S_DONE;
                    end else begin
                        rcnt_reg <= rcnt_reg + 4'd1;
                    end
                end
                S_DONE: begin
                    if (hash_ready) begin
                        hash_valid_reg <= 1'b0;
                        last_f_reg     <= 1'b0;
                        busy_reg       <= 1'b0;
                        state_reg      <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule
